// File: rtl/gamma_cycle_controller_pkg.sv
// Shared sizes, FSM encoding and result payload for the gamma cycle controller.
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 3
`endif
`ifndef NEURONS_PER_LAYER
`define NEURONS_PER_LAYER 8
`endif
`ifndef LOG_NEURONS_PER_LAYER
`define LOG_NEURONS_PER_LAYER 3
`endif

package gamma_cycle_controller_pkg;

    localparam int unsigned LOG_TP = `LOG_TIME_PERIOD;
    localparam int unsigned TP     = 32'd1 << LOG_TP;
    localparam int unsigned N      = `NEURONS_PER_LAYER;
    localparam int unsigned LOG_N  = `LOG_NEURONS_PER_LAYER;

    // time_val needs one extra bit so it can park at TP outside RUN
    localparam int unsigned TW     = LOG_TP + 1;
    // winner index carries one extra bit so all-ones can mean "no winner"
    localparam int unsigned WW     = LOG_N + 1;

    localparam logic [WW-1:0] NO_WINNER = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              spike;
        logic [LOG_TP-1:0] spike_time;
        logic [WW-1:0]     neuron;
    } result_t;

    localparam result_t RESULT_NONE = '{spike: 1'b0, spike_time: '0, neuron: NO_WINNER};

endpackage

// File: rtl/gamma_cycle_controller_spike_priority_encoder.sv
// Lowest-index-wins priority encoder over one spike volley; purely combinational.
module spike_priority_encoder #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  volley,
    output logic [IW-1:0] index_c,
    output logic          any_valid_c
);

    // Scan from the top down so the lowest set bit is the last write and wins.
    always_comb begin
        index_c     = '0;
        any_valid_c = |volley;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (volley[i]) begin
                index_c = IW'(i);
            end
        end
    end

endmodule

// File: rtl/gamma_cycle_controller.sv
// Gamma cycle controller: clears the column, sweeps time steps, latches the
// first spiking neuron as winner and hands the result out over valid/ready.
module gamma_cycle_controller
    import gamma_cycle_controller_pkg::*;
#(
    parameter bit EARLY_TERMINATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N-1:0]      spike_volley,
    output logic              clear_neurons,
    output logic [TW-1:0]     time_val,
    output logic              inhibit,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              output_spike,
    output logic [LOG_TP-1:0] output_spike_time,
    output logic [WW-1:0]     winning_neuron
);

    state_t        state_q;
    state_t        state_d;
    result_t       result_q;
    result_t       result_d;
    logic [TW-1:0] time_val_d;
    logic          clear_d;
    logic          inhibit_d;
    logic          busy_d;
    logic          valid_d;

    logic [LOG_N-1:0] enc_idx_c;
    logic             enc_any_c;
    logic             capture_c;
    logic             last_step_c;

    spike_priority_encoder #(
        .N  (N),
        .IW (LOG_N)
    ) u_spike_priority_encoder (
        .volley      (spike_volley),
        .index_c     (enc_idx_c),
        .any_valid_c (enc_any_c)
    );

    // Only the first spiking RUN step may claim the winner slot.
    assign capture_c   = (state_q == RUN) && enc_any_c && !result_q.spike;
    assign last_step_c = (time_val == TW'(TP - 1));

    // Next state plus the next value of every registered output.
    always_comb begin
        state_d    = state_q;
        time_val_d = TW'(TP);
        result_d   = result_q;
        clear_d    = 1'b0;
        inhibit_d  = 1'b0;
        busy_d     = 1'b0;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = RUN;
            end
            RUN: begin
                if ((EARLY_TERMINATE && capture_c) || last_step_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            CLEAR:   time_val_d = '0;
            RUN:     time_val_d = (state_q == RUN) ? (time_val + TW'(1)) : '0;
            default: time_val_d = TW'(TP);
        endcase

        if (state_d == CLEAR) begin
            result_d = RESULT_NONE;
        end else if (capture_c) begin
            result_d = '{spike:      1'b1,
                         spike_time: time_val[LOG_TP-1:0],
                         neuron:     WW'(enc_idx_c)};
        end

        clear_d   = (state_d == CLEAR);
        busy_d    = (state_d != IDLE);
        valid_d   = (state_d == DONE);
        inhibit_d = result_d.spike && ((state_d == RUN) || (state_d == DONE));
    end

    // State and output registers; reset drops any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            time_val      <= TW'(TP);
            result_q      <= RESULT_NONE;
            clear_neurons <= 1'b0;
            inhibit       <= 1'b0;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            state_q       <= state_d;
            time_val      <= time_val_d;
            result_q      <= result_d;
            clear_neurons <= clear_d;
            inhibit       <= inhibit_d;
            busy          <= busy_d;
            out_valid     <= valid_d;
        end
    end

    assign output_spike      = result_q.spike;
    assign output_spike_time = result_q.spike_time;
    assign winning_neuron    = result_q.neuron;

endmodule

// File: tb/tb_gamma_cycle_controller.sv
// Self-checking bench: directed vector table, reset corner case and random
// gamma cycles against a transaction-level reference of the winner rules.
module tb_gamma_cycle_controller;
    import gamma_cycle_controller_pkg::*;

    localparam int NO_WIN = (1 << WW) - 1;

    logic clk;
    logic rst_n;

    // index 0: full-period instance, index 1: early-terminate instance
    logic              start_i  [2];
    logic [N-1:0]      volley_i [2];
    logic              ready_i  [2];
    logic              clear_o  [2];
    logic [TW-1:0]     tval_o   [2];
    logic              inhib_o  [2];
    logic              busy_o   [2];
    logic              valid_o  [2];
    logic              spike_o  [2];
    logic [LOG_TP-1:0] stime_o  [2];
    logic [WW-1:0]     wn_o     [2];

    gamma_cycle_controller #(.EARLY_TERMINATE(1'b0)) u_dut_full (
        .clk (clk), .rst_n (rst_n), .start (start_i[0]), .spike_volley (volley_i[0]),
        .clear_neurons (clear_o[0]), .time_val (tval_o[0]), .inhibit (inhib_o[0]),
        .busy (busy_o[0]), .out_valid (valid_o[0]), .out_ready (ready_i[0]),
        .output_spike (spike_o[0]), .output_spike_time (stime_o[0]),
        .winning_neuron (wn_o[0])
    );

    gamma_cycle_controller #(.EARLY_TERMINATE(1'b1)) u_dut_early (
        .clk (clk), .rst_n (rst_n), .start (start_i[1]), .spike_volley (volley_i[1]),
        .clear_neurons (clear_o[1]), .time_val (tval_o[1]), .inhibit (inhib_o[1]),
        .busy (busy_o[1]), .out_valid (valid_o[1]), .out_ready (ready_i[1]),
        .output_spike (spike_o[1]), .output_spike_time (stime_o[1]),
        .winning_neuron (wn_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // per-step volleys for the next gamma cycle
    logic [N-1:0] vols [TP];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference: first nonzero step wins, neuron = count of trailing zeros.
    task automatic model(output bit win, output int wstep, output int wneu);
        logic [N-1:0] x;
        win   = 1'b0;
        wstep = 0;
        wneu  = NO_WIN;
        for (int t = 0; t < int'(TP); t++) begin
            if (!win && (vols[t] != '0)) begin
                win   = 1'b1;
                wstep = t;
                x     = vols[t];
                wneu  = 0;
                while (x[0] == 1'b0) begin
                    x = x >> 1;
                    wneu++;
                end
            end
        end
    endtask

    task automatic check_reset(input int d, input string tag);
        chk($sformatf("%s d%0d time_val", tag, d), int'(tval_o[d]), int'(TP));
        chk($sformatf("%s d%0d clear", tag, d), int'(clear_o[d]), 0);
        chk($sformatf("%s d%0d inhibit", tag, d), int'(inhib_o[d]), 0);
        chk($sformatf("%s d%0d busy", tag, d), int'(busy_o[d]), 0);
        chk($sformatf("%s d%0d out_valid", tag, d), int'(valid_o[d]), 0);
        chk($sformatf("%s d%0d spike", tag, d), int'(spike_o[d]), 0);
        chk($sformatf("%s d%0d spike_time", tag, d), int'(stime_o[d]), 0);
        chk($sformatf("%s d%0d winner", tag, d), int'(wn_o[d]), NO_WIN);
    endtask

    // One full gamma cycle on instance d; every cycle checked against the model.
    // Cycle k=0 carries start, k=1 is CLEAR, then RUN steps, then DONE.
    task automatic run_txn(input int d, input int rdly,
                           output int o_spike, output int o_time,
                           output int o_neu, output int o_lat);
        bit    win;
        bit    latched;
        int    wstep;
        int    wneu;
        int    done_k;
        string tg;
        model(win, wstep, wneu);
        done_k  = (d == 1 && win) ? wstep + 3 : int'(TP) + 2;
        o_lat   = -1;
        o_spike = -1;
        o_time  = -1;
        o_neu   = -1;

        @(negedge clk);
        chk($sformatf("d%0d k0 busy", d), int'(busy_o[d]), 0);
        chk($sformatf("d%0d k0 time_val", d), int'(tval_o[d]), int'(TP));
        if (valid_o[d] && o_lat < 0) o_lat = 0;
        start_i[d]  = 1'b1;
        volley_i[d] = N'($urandom);
        ready_i[d]  = 1'($urandom_range(0, 1));

        for (int k = 1; k < done_k; k++) begin
            @(negedge clk);
            tg = $sformatf("d%0d k%0d", d, k);
            if (valid_o[d] && o_lat < 0) o_lat = k;
            latched = win && (k > wstep + 2);
            chk({tg, " clear"}, int'(clear_o[d]), int'(k == 1));
            chk({tg, " time_val"}, int'(tval_o[d]), (k == 1) ? 0 : k - 2);
            chk({tg, " busy"}, int'(busy_o[d]), 1);
            chk({tg, " out_valid"}, int'(valid_o[d]), 0);
            chk({tg, " inhibit"}, int'(inhib_o[d]), int'(latched));
            chk({tg, " spike"}, int'(spike_o[d]), int'(latched));
            chk({tg, " spike_time"}, int'(stime_o[d]), latched ? wstep : 0);
            chk({tg, " winner"}, int'(wn_o[d]), latched ? wneu : NO_WIN);
            start_i[d]  = (k <= 2);
            volley_i[d] = (k == 1) ? N'($urandom) : vols[k-2];
            ready_i[d]  = 1'($urandom_range(0, 1));
        end

        for (int j = 0; j <= rdly; j++) begin
            @(negedge clk);
            tg = $sformatf("d%0d done%0d", d, j);
            if (valid_o[d] && o_lat < 0) o_lat = done_k + j;
            if (j == 0) begin
                o_spike = int'(spike_o[d]);
                o_time  = int'(stime_o[d]);
                o_neu   = int'(wn_o[d]);
            end
            chk({tg, " out_valid"}, int'(valid_o[d]), 1);
            chk({tg, " busy"}, int'(busy_o[d]), 1);
            chk({tg, " clear"}, int'(clear_o[d]), 0);
            chk({tg, " time_val"}, int'(tval_o[d]), int'(TP));
            chk({tg, " inhibit"}, int'(inhib_o[d]), int'(win));
            chk({tg, " spike"}, int'(spike_o[d]), int'(win));
            chk({tg, " spike_time"}, int'(stime_o[d]), win ? wstep : 0);
            chk({tg, " winner"}, int'(wn_o[d]), win ? wneu : NO_WIN);
            start_i[d]  = (j == rdly) ? 1'b1 : 1'($urandom_range(0, 1));
            ready_i[d]  = (j == rdly);
            volley_i[d] = N'($urandom);
        end

        @(negedge clk);
        tg = $sformatf("d%0d post", d);
        chk({tg, " out_valid"}, int'(valid_o[d]), 0);
        chk({tg, " busy"}, int'(busy_o[d]), 0);
        chk({tg, " clear"}, int'(clear_o[d]), 0);
        chk({tg, " time_val"}, int'(tval_o[d]), int'(TP));
        chk({tg, " inhibit"}, int'(inhib_o[d]), 0);
        start_i[d] = 1'b0;
        ready_i[d] = 1'b0;

        @(negedge clk);
        chk($sformatf("d%0d idle busy", d), int'(busy_o[d]), 0);
        chk($sformatf("d%0d idle clear", d), int'(clear_o[d]), 0);
        volley_i[d] = '0;
    endtask

    typedef struct {
        int           dut;
        int           step_a;
        logic [N-1:0] vol_a;
        int           step_b;
        logic [N-1:0] vol_b;
        int           rdly;
        int           exp_spike;
        int           exp_time;
        int           exp_neuron;
        int           exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: time actual %0t required completion earlier", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int os, ot, on, ol;

        vecs[0] = '{0,  3, 8'b0001_0000, -1, 8'h00, 0, 1, 3, 4,      10};
        vecs[1] = '{0,  0, 8'b1010_0100,  1, 8'h01, 1, 1, 0, 2,      10};
        vecs[2] = '{0, -1, 8'h00,        -1, 8'h00, 2, 0, 0, NO_WIN, 10};
        vecs[3] = '{0,  7, 8'b0100_0000, -1, 8'h00, 5, 1, 7, 6,      10};
        vecs[4] = '{1,  2, 8'b0100_0000, -1, 8'h00, 0, 1, 2, 6,      5};
        vecs[5] = '{1, -1, 8'h00,        -1, 8'h00, 1, 0, 0, NO_WIN, 10};
        vecs[6] = '{1,  7, 8'b1000_0001, -1, 8'h00, 3, 1, 7, 0,      10};
        vecs[7] = '{0,  0, 8'hFF,        -1, 8'h00, 0, 1, 0, 0,      10};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_i[d]  = 1'b0;
            volley_i[d] = '0;
            ready_i[d]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) check_reset(d, "por");
        rst_n = 1'b1;

        // Directed vector table
        for (int v = 0; v < 8; v++) begin
            for (int t = 0; t < int'(TP); t++) vols[t] = '0;
            if (vecs[v].step_a >= 0) vols[vecs[v].step_a] = vecs[v].vol_a;
            if (vecs[v].step_b >= 0) vols[vecs[v].step_b] = vecs[v].vol_b;
            run_txn(vecs[v].dut, vecs[v].rdly, os, ot, on, ol);
            chk($sformatf("vec%0d spike", v), os, vecs[v].exp_spike);
            chk($sformatf("vec%0d spike_time", v), ot, vecs[v].exp_time);
            chk($sformatf("vec%0d winner", v), on, vecs[v].exp_neuron);
            chk($sformatf("vec%0d latency", v), ol, vecs[v].exp_lat);
        end

        // Reset at step 5 with a winner already latched
        @(negedge clk);
        start_i[0] = 1'b1;
        @(negedge clk);
        chk("rst clear pulse", int'(clear_o[0]), 1);
        start_i[0] = 1'b0;
        for (int s = 0; s <= 5; s++) begin
            @(negedge clk);
            chk($sformatf("rst step%0d time_val", s), int'(tval_o[0]), s);
            volley_i[0] = (s == 2) ? N'(8'b0000_0010) : '0;
        end
        chk("rst pre winner", int'(wn_o[0]), 1);
        chk("rst pre inhibit", int'(inhib_o[0]), 1);
        rst_n = 1'b0;
        #1;
        check_reset(0, "midrun");
        @(negedge clk);
        rst_n = 1'b1;
        volley_i[0] = N'(8'b0000_0100);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("rst quiet%0d out_valid", c), int'(valid_o[0]), 0);
            chk($sformatf("rst quiet%0d busy", c), int'(busy_o[0]), 0);
        end
        volley_i[0] = '0;
        for (int t = 0; t < int'(TP); t++) vols[t] = '0;
        vols[4] = N'(8'b0000_1000);
        run_txn(0, 1, os, ot, on, ol);
        chk("rst fresh spike", os, 1);
        chk("rst fresh spike_time", ot, 4);
        chk("rst fresh winner", on, 3);
        chk("rst fresh latency", ol, 10);

        // Random gamma cycles on both instances
        for (int r = 0; r < 30; r++) begin
            for (int t = 0; t < int'(TP); t++) begin
                vols[t] = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
            end
            run_txn($urandom_range(0, 1), $urandom_range(0, 3), os, ot, on, ol);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
